// File: rtl/lcd_text_refresh.sv
// lcd_text_refresh: shadow text buffer for a 16x2 character LCD.
// After reset it sends the LCD configuration commands, then scans the
// buffer round-robin and sends only the characters that changed, using
// the command/write/ack four-phase handshake of the LCD engine.
module lcd_text_refresh #(
  parameter logic [6:0] ROW1_BASE    = 7'h40,
  parameter logic [7:0] DISPLAY_CTRL = 8'h0C,
  parameter logic [7:0] ENTRY_MODE   = 8'h06
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       char_we,
  input  logic [4:0] char_addr,
  input  logic [7:0] char_wdata,
  output logic [7:0] char_rdata,
  output logic       cfg_done,
  output logic       idle,
  output logic [8:0] lcd_command,
  output logic       lcd_write,
  input  logic       lcd_ack
);

  typedef enum logic [2:0] {CFG, SCAN, ADDR, DATA, W_ACK, W_REL} state_t;

  state_t      state_reg, state_next, ret_state_reg;
  logic [7:0]  buffer [32];
  logic [31:0] dirty_reg;
  logic [4:0]  ptr_reg, idx_reg;
  logic [7:0]  ch_reg;
  logic [6:0]  cursor_reg;
  logic        cursor_valid_reg;
  logic [1:0]  cfg_idx_reg;
  logic        cfg_done_reg;
  logic [8:0]  command_reg;
  logic        write_reg;

  // Decoded strobes produced by the output process
  logic        issue;
  logic [8:0]  issue_command;
  logic        released;
  logic        latch;

  // DDRAM address of a buffer index: bit 4 selects the row
  function automatic logic [6:0] ddram(input logic [4:0] a);
    return (a[4] ? ROW1_BASE : 7'h00) + {3'b000, a[3:0]};
  endfunction

  // Configuration command ROM, issued in order after reset
  function automatic logic [8:0] cfg_rom(input logic [1:0] i);
    case (i)
      2'd0:    return 9'h028;
      2'd1:    return {1'b0, DISPLAY_CTRL};
      2'd2:    return {1'b0, ENTRY_MODE};
      default: return 9'h001;
    endcase
  endfunction

  logic [6:0] ptr_ddram, idx_ddram;
  logic       cursor_hit;
  assign ptr_ddram  = ddram(ptr_reg);
  assign idx_ddram  = ddram(idx_reg);
  // The LCD cursor already points at the cell being latched: skip set-address
  assign cursor_hit = cursor_valid_reg && (cursor_reg == ptr_ddram);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_reg <= CFG;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CFG, ADDR, DATA: if (!lcd_ack) state_next = W_ACK;
      SCAN:  if (dirty_reg[ptr_reg]) state_next = cursor_hit ? DATA : ADDR;
      W_ACK: if (lcd_ack) state_next = W_REL;
      W_REL: begin
        if (!lcd_ack) begin
          case (ret_state_reg)
            CFG:     state_next = (cfg_idx_reg == 2'd3) ? SCAN : CFG;
            ADDR:    state_next = DATA;
            default: state_next = SCAN;
          endcase
        end
      end
      default: state_next = CFG;
    endcase
  end

  // Output decode: command to launch, handshake release and scan latch strobes
  always_comb begin
    issue         = 1'b0;
    issue_command = 9'h000;
    case (state_reg)
      CFG:  begin issue = !lcd_ack; issue_command = cfg_rom(cfg_idx_reg); end
      ADDR: begin issue = !lcd_ack; issue_command = {2'b01, idx_ddram}; end
      DATA: begin issue = !lcd_ack; issue_command = {1'b1, ch_reg}; end
      default: ;
    endcase
    released = (state_reg == W_REL) && !lcd_ack;
    latch    = (state_reg == SCAN) && dirty_reg[ptr_reg];
  end

  // Per-entry buffer storage and dirty flags; a host write beats the scan clear
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_entry
      always_ff @(posedge clock) begin
        if (reset) begin
          buffer[gi]    <= 8'h20;
          dirty_reg[gi] <= 1'b0;
        end else if (char_we && (char_addr == 5'(gi))) begin
          buffer[gi]    <= char_wdata;
          dirty_reg[gi] <= 1'b1;
        end else if (latch && (ptr_reg == 5'(gi))) begin
          dirty_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Handshake driver, scan pointer, cursor tracking and config progress
  always_ff @(posedge clock) begin
    if (reset) begin
      command_reg      <= 9'h000;
      write_reg        <= 1'b0;
      ret_state_reg    <= CFG;
      ptr_reg          <= 5'd0;
      idx_reg          <= 5'd0;
      ch_reg           <= 8'h00;
      cursor_reg       <= 7'h00;
      cursor_valid_reg <= 1'b0;
      cfg_idx_reg      <= 2'd0;
      cfg_done_reg     <= 1'b0;
    end else begin
      if (issue) begin
        command_reg   <= issue_command;
        write_reg     <= 1'b1;
        ret_state_reg <= state_reg;
      end else if (state_reg == W_ACK && lcd_ack) begin
        write_reg <= 1'b0;
      end

      // The clear command homes the LCD cursor, so our copy is unknown
      if (state_reg == CFG) cursor_valid_reg <= 1'b0;

      if (state_reg == SCAN) begin
        if (dirty_reg[ptr_reg]) begin
          idx_reg <= ptr_reg;
          ch_reg  <= buffer[ptr_reg];
        end else begin
          ptr_reg <= ptr_reg + 5'd1;
        end
      end

      if (released) begin
        case (ret_state_reg)
          CFG: begin
            if (cfg_idx_reg == 2'd3) cfg_done_reg <= 1'b1;
            cfg_idx_reg <= cfg_idx_reg + 2'd1;
          end
          DATA: begin
            cursor_reg       <= idx_ddram + 7'd1;
            cursor_valid_reg <= 1'b1;
            ptr_reg          <= idx_reg + 5'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign char_rdata  = buffer[char_addr];
  assign cfg_done    = cfg_done_reg;
  assign lcd_command = command_reg;
  assign lcd_write   = write_reg;
  assign idle        = cfg_done_reg && (dirty_reg == 32'h0) && (state_reg == SCAN)
                       && !write_reg && !lcd_ack;

endmodule

// File: tb/tb_lcd_text_refresh.sv
// Bench for lcd_text_refresh: directed host writes, a 3-cycle-latency
// LCD engine ack model, an LCD display/cursor model fed by the observed
// command stream, and literal expected command sequences.
module tb_lcd_text_refresh;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       char_we = 1'b0;
  logic [4:0] char_addr = 5'd0;
  logic [7:0] char_wdata = 8'h00;
  logic [7:0] char_rdata;
  logic       cfg_done, idle;
  logic [8:0] lcd_command;
  logic       lcd_write;
  logic       lcd_ack;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_q[$];
  logic [7:0] model_buf [32];
  logic [7:0] lcd_ram [128];
  logic [6:0] lcd_cur;
  bit         cur_known;

  lcd_text_refresh dut (
    .clock(clock), .reset(reset), .char_we(char_we), .char_addr(char_addr),
    .char_wdata(char_wdata), .char_rdata(char_rdata), .cfg_done(cfg_done),
    .idle(idle), .lcd_command(lcd_command), .lcd_write(lcd_write), .lcd_ack(lcd_ack)
  );

  always #5 clock = ~clock;

  // LCD engine: ack three cycles after write rises, drop ack one cycle after write drops
  int ack_cnt;
  always @(posedge clock) begin
    if (reset) begin
      lcd_ack <= 1'b0;
      ack_cnt <= 0;
    end else if (lcd_write && !lcd_ack) begin
      if (ack_cnt == 2) begin
        lcd_ack <= 1'b1;
        ack_cnt <= 0;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end else if (!lcd_write && lcd_ack) begin
      lcd_ack <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [6:0] cell_addr(input int i);
    return (i >= 16 ? 7'h40 : 7'h00) + 7'(i % 16);
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic write_char(input int a, input logic [7:0] d);
    char_we    = 1'b1;
    char_addr  = 5'(a);
    char_wdata = d;
    tick;
    model_buf[a] = d;
    char_we = 1'b0;
    $display("write addr=%0d data=%02h", a, d);
  endtask

  task automatic push(input logic [8:0] c);
    exp_q.push_back(c);
  endtask

  task automatic check_display;
    for (int i = 0; i < 32; i++)
      chk($sformatf("display[%0d]", i), 32'(lcd_ram[cell_addr(i)]), 32'(model_buf[i]));
  endtask

  task automatic wait_idle;
    int n;
    repeat (3) tick;
    n = 0;
    while (!idle && n < 3000) begin
      tick;
      n++;
    end
    chk("idle_reached", 32'(idle), 32'd1);
    chk("cfg_done", 32'(cfg_done), 32'd1);
    chk("expected_cmds_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check_display();
  endtask

  // Per-cycle compare: readback, handshake protocol, command stream and LCD model
  initial begin
    logic       prev_w, prev_a;
    logic [8:0] prev_cmd, e;
    prev_w = 1'b0; prev_a = 1'b0; prev_cmd = 9'h000;
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("char_rdata", 32'(char_rdata), 32'(model_buf[char_addr]));
        if (lcd_write && prev_w)
          chk("cmd_stable", 32'(lcd_command), 32'(prev_cmd));
        if (lcd_write && !prev_w) begin
          $display("cmd %03h", lcd_command);
          chk("write_rise_while_ack", 32'(prev_a), 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cmd: got %03h expected none", lcd_command);
          end else begin
            e = exp_q.pop_front();
            chk("cmd", 32'(lcd_command), 32'(e));
          end
          if (lcd_command == 9'h001)
            chk("cfg_done_before_clear_release", 32'(cfg_done), 32'd0);
          if (lcd_command[8]) begin
            chk("data_cursor_known", 32'(cur_known), 32'd1);
            lcd_ram[lcd_cur] = lcd_command[7:0];
            lcd_cur = lcd_cur + 7'd1;
          end else if (lcd_command[7]) begin
            if (cur_known)
              chk("addr_cmd_needed", 32'(lcd_command[6:0] != lcd_cur), 32'd1);
            lcd_cur   = lcd_command[6:0];
            cur_known = 1'b1;
          end else if (lcd_command[7:0] == 8'h01) begin
            for (int i = 0; i < 128; i++) lcd_ram[i] = 8'h20;
            lcd_cur   = 7'h00;
            cur_known = 1'b0;
          end
        end
      end
      prev_w   = lcd_write;
      prev_a   = lcd_ack;
      prev_cmd = lcd_command;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int  n;
    bit  found;
    logic pa;
    for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
    for (int i = 0; i < 128; i++) lcd_ram[i] = 8'h20;
    lcd_cur = 7'h00;
    cur_known = 1'b0;

    // Reset values
    repeat (3) tick;
    chk("rst_lcd_write", 32'(lcd_write), 32'd0);
    chk("rst_lcd_command", 32'(lcd_command), 32'd0);
    chk("rst_cfg_done", 32'(cfg_done), 32'd0);
    chk("rst_idle", 32'(idle), 32'd0);
    chk("rst_char_rdata", 32'(char_rdata), 32'h20);

    // Configuration sequence
    push(9'h028); push(9'h00C); push(9'h006); push(9'h001);
    reset = 1'b0;
    wait_idle();

    // Row 0 write needs an address; the neighbour hits the cursor
    push(9'h080); push(9'h141);
    write_char(0, 8'h41);
    wait_idle();
    push(9'h142);
    write_char(1, 8'h42);
    wait_idle();

    // Row 1 base
    push(9'h0C0); push(9'h143);
    write_char(16, 8'h43);
    wait_idle();

    // End of row 0 then start of row 1: cursor 0x10 is not 0x40
    push(9'h08F); push(9'h158); push(9'h0C0); push(9'h159);
    write_char(15, 8'h58);
    write_char(16, 8'h59);
    wait_idle();

    // Rewrite addr 5 in the very cycle the scan latches it
    push(9'h084); push(9'h151); push(9'h150); push(9'h085); push(9'h152);
    write_char(4, 8'h51);
    write_char(5, 8'h50);
    found = 1'b0;
    n = 0;
    pa = lcd_ack;
    while (!found && n < 500) begin
      tick;
      if (pa && !lcd_ack && lcd_command == 9'h151) found = 1'b1;
      pa = lcd_ack;
      n++;
    end
    chk("release_of_Q_seen", 32'(found), 32'd1);
    tick;
    write_char(5, 8'h52);
    wait_idle();

    // Reset in the middle of a handshake
    push(9'h080);
    write_char(0, 8'h5A);
    found = 1'b0;
    n = 0;
    while (!found && n < 500) begin
      tick;
      if (lcd_write) found = 1'b1;
      n++;
    end
    chk("write_seen_before_reset", 32'(found), 32'd1);
    reset = 1'b1;
    tick;
    chk("write_drop_on_reset", 32'(lcd_write), 32'd0);
    chk("cfg_done_cleared", 32'(cfg_done), 32'd0);
    for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
    exp_q.delete();
    tick;
    push(9'h028); push(9'h00C); push(9'h006); push(9'h001);
    reset = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
